// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: machine word, the
// canonical NOP used when decode has nothing to consume, and the queued
// {pc, inst} entry.
package fetch_queue_pkg;

   typedef logic [31:0] word_t;

   // addi x0, x0, 0
   localparam word_t NOP_INST = 32'h0000_0013;

   typedef struct packed {
      word_t pc;
      word_t inst;
   } fetch_entry_t;

   // Fetch addresses are always word aligned; low bits of a target are dropped.
   function automatic word_t align_word(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, the instruction RAM port, the
// redirect/halt sources and the decode stage. The master modport is the
// fetch queue itself; the slave modport is its environment.
interface fetch_queue_if;
   import fetch_queue_pkg::*;

   // instruction RAM side
   logic  iren;
   word_t iaddr;
   word_t iload;
   logic  iwait;

   // control from execute / pipeline control
   logic  redirect;
   word_t redirect_pc;
   logic  halt;

   // decode side
   logic  out_valid;
   word_t out_pc;
   word_t out_inst;
   logic  out_ready;

   modport master (
      output iren, iaddr, out_valid, out_pc, out_inst,
      input  iload, iwait, redirect, redirect_pc, halt, out_ready
   );

   modport slave (
      input  iren, iaddr, out_valid, out_pc, out_inst,
      output iload, iwait, redirect, redirect_pc, halt, out_ready
   );

endinterface

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry circular buffer of fetch entries. Pointers and count are reset
// asynchronously; the storage array is not reset since nothing reads it
// until it has been written. Flush has priority over push and pop.
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  fetch_entry_t       wr_entry,
   output fetch_entry_t       rd_entry,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];

   logic do_push;
   logic do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   assign do_push  = push & ~full & ~flush;
   assign do_pop   = pop & ~empty & ~flush;
   assign rd_entry = mem_q[rd_ptr_q];

   // pointer and occupancy update
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage write port
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = wr_entry;
   end

   // storage array, intentionally without reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction prefetch queue for the RV32 front end. Issues
// sequential word fetches from fetch_pc, buffers up to DEPTH responses and
// hands them to decode over valid/ready. Redirect flushes and restarts;
// halt stops issue while the queue drains.
// Optional build macro FETCH_QUEUE_BYPASS_EN: a response arriving into an
// empty queue is shown to decode in the same cycle (and not stored if taken).
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0,
   parameter int    DEPTH   = 4
) (
   input logic           clk,
   input logic           nrst,
   fetch_queue_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   word_t fetch_pc_q, fetch_pc_d;

   logic             iren;
   logic             push;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     fifo_head;
   fetch_entry_t     new_entry;

   logic  out_valid;
   word_t out_pc;
   word_t out_inst;

   // Occupancy is read through full/empty; the raw count is not needed here.
   logic unused_fifo_count;
   assign unused_fifo_count = ^fifo_count;

   // Request issue: a full queue blocks issue even when decode pops this cycle,
   // and nothing is requested while reset is held.
   always_comb begin
      iren = nrst & ~bus.halt & ~bus.redirect & ~fifo_full;
      push = iren & ~bus.iwait;
   end

   // Next fetch PC: redirect wins, otherwise advance on each accepted response.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (bus.redirect)  fetch_pc_d = align_word(bus.redirect_pc);
      else if (push)     fetch_pc_d = fetch_pc_q + 32'd4;
   end

   // fetch PC register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) fetch_pc_q <= PC_INIT;
      else       fetch_pc_q <= fetch_pc_d;
   end

   assign new_entry = '{pc: fetch_pc_q, inst: bus.iload};

   // Decode-side output mux and queue push/pop steering.
   always_comb begin
      out_valid = ~fifo_empty;
      out_pc    = fifo_empty ? fetch_pc_q : fifo_head.pc;
      out_inst  = fifo_empty ? NOP_INST   : fifo_head.inst;
      fifo_push = push;
      fifo_pop  = bus.out_ready & ~fifo_empty;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (fifo_empty && push) begin
         out_valid = 1'b1;
         out_pc    = fetch_pc_q;
         out_inst  = bus.iload;
         // taken straight from the memory port, so it never occupies a slot
         if (bus.out_ready) fifo_push = 1'b0;
      end
`endif
   end

   fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .nrst     (nrst),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .flush    (bus.redirect),
      .wr_entry (new_entry),
      .rd_entry (fifo_head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign bus.iren      = iren;
   assign bus.iaddr     = fetch_pc_q;
   assign bus.out_valid = out_valid;
   assign bus.out_pc    = out_pc;
   assign bus.out_inst  = out_inst;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. A reference model tracks the fetch PC and
// a scoreboard queue of expected {pc, inst} entries: an entry is pushed when
// the model sees a response accepted and popped when decode takes it.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam word_t PC_INIT = 32'h0;
   localparam int    DEPTH   = 4;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   fetch_queue_if bus_if ();

   fetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus_if)
   );

   function automatic word_t mem_word(input word_t a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign bus_if.iload = mem_word(bus_if.iaddr);

   int           checks = 0;
   int           errors = 0;
   int           cyc    = 0;
   fetch_entry_t sb [$];
   word_t        exp_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_iren",      {31'b0, bus_if.iren},      32'h0);
      chk("rst_iaddr",     bus_if.iaddr,              PC_INIT);
      chk("rst_out_valid", {31'b0, bus_if.out_valid}, 32'h0);
      chk("rst_out_pc",    bus_if.out_pc,             PC_INIT);
      chk("rst_out_inst",  bus_if.out_inst,           NOP_INST);
   endtask

   // One clock of model + comparison; called just after a falling edge with
   // the inputs for this cycle already driven.
   task automatic step();
      logic         e_iren, e_push, e_valid, consumed;
      fetch_entry_t head;
      #1;
      e_iren   = nrst & ~bus_if.halt & ~bus_if.redirect & (sb.size() < DEPTH);
      e_push   = e_iren & ~bus_if.iwait;
      e_valid  = (sb.size() != 0);
      head     = (sb.size() != 0) ? sb[0] : '0;
      consumed = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (sb.size() == 0 && e_push) begin
         e_valid  = 1'b1;
         head     = '{pc: exp_pc, inst: mem_word(exp_pc)};
         consumed = bus_if.out_ready;
      end
`endif
      chk("iren",      {31'b0, bus_if.iren},      {31'b0, e_iren});
      chk("iaddr",     bus_if.iaddr,              exp_pc);
      chk("out_valid", {31'b0, bus_if.out_valid}, {31'b0, e_valid});
      if (e_valid) begin
         chk("out_pc",   bus_if.out_pc,   head.pc);
         chk("out_inst", bus_if.out_inst, head.inst);
      end else begin
         chk("out_inst_nop", bus_if.out_inst, NOP_INST);
      end
      if (bus_if.out_ready && sb.size() != 0) void'(sb.pop_front());
      if (bus_if.redirect) begin
         sb.delete();
         exp_pc = {bus_if.redirect_pc[31:2], 2'b00};
      end else if (e_push) begin
         if (!consumed) sb.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
         exp_pc = exp_pc + 32'd4;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      nrst               = 1'b0;
      bus_if.iwait       = 1'b0;
      bus_if.redirect    = 1'b0;
      bus_if.redirect_pc = '0;
      bus_if.halt        = 1'b0;
      bus_if.out_ready   = 1'b0;
      exp_pc             = PC_INIT;

      // reset state
      #12;
      chk_reset_outputs();
      @(negedge clk);
      nrst = 1'b1;

      // streaming with decode always ready
      bus_if.out_ready = 1'b1;
      run(6);

      // fill to DEPTH with decode stalled, then drain in order and refill
      bus_if.out_ready = 1'b0;
      run(6);
      bus_if.out_ready = 1'b1;
      run(8);

      // redirect with a partly filled queue; pop in the redirect cycle
      bus_if.out_ready = 1'b0;
      run(3);
      bus_if.redirect    = 1'b1;
      bus_if.redirect_pc = 32'h0000_0103;
      bus_if.out_ready   = 1'b1;
      step();
      bus_if.redirect  = 1'b0;
      bus_if.out_ready = 1'b0;
      step();
      bus_if.out_ready = 1'b1;
      run(4);

      // back-to-back redirects: second target wins
      bus_if.redirect    = 1'b1;
      bus_if.redirect_pc = 32'h0000_0200;
      step();
      bus_if.redirect_pc = 32'h0000_001E;
      step();
      bus_if.redirect = 1'b0;
      run(1);

      // memory stall at iaddr 0x20
      bus_if.iwait = 1'b1;
      run(3);
      bus_if.iwait = 1'b0;
      run(3);

      // halt: queue two entries, drain them under halt, then resume
      bus_if.halt = 1'b1;
      run(3);
      bus_if.halt      = 1'b0;
      bus_if.out_ready = 1'b0;
      run(2);
      bus_if.halt      = 1'b1;
      bus_if.out_ready = 1'b1;
      run(4);
      bus_if.halt = 1'b0;
      run(3);

      // redirect honoured while halted
      bus_if.halt        = 1'b1;
      bus_if.redirect    = 1'b1;
      bus_if.redirect_pc = 32'h0000_0400;
      step();
      bus_if.redirect = 1'b0;
      run(2);
      bus_if.halt = 1'b0;
      run(3);

      // full queue blocks issue even with a pop the same cycle
      bus_if.out_ready = 1'b0;
      run(5);
      bus_if.out_ready = 1'b1;
      run(5);

      // PC wraps past 2^32
      bus_if.redirect    = 1'b1;
      bus_if.redirect_pc = 32'hFFFF_FFF8;
      step();
      bus_if.redirect = 1'b0;
      run(5);

      // asynchronous reset mid-stream
      bus_if.out_ready = 1'b0;
      run(2);
      #2;
      nrst = 1'b0;
      #1;
      chk_reset_outputs();
      sb.delete();
      exp_pc = PC_INIT;
      @(negedge clk);
      nrst             = 1'b1;
      bus_if.out_ready = 1'b1;
      run(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
